// File: rtl/instr_trace_uart_tx.sv
// Instruction-trace UART transmitter: buffers retired instructions and
// sends each as four little-endian 8N1 frames, flagging the halt word.
module instr_trace_uart_tx #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] HALT_INSTR   = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        txd,
    output logic        fifo_full,
    output logic        overflow,
    output logic        busy,
    output logic        halted
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [1:0]    byte_q, byte_d;
    logic [2:0]    bit_q, bit_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [31:0]   shreg_q, shreg_d;
    logic          txd_q, txd_d;
    logic          halt_seen_q, halt_seen_d;
    logic          overflow_q, overflow_d;
    logic          halted_q, halted_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   mem_q [FIFO_DEPTH];

    logic full, pop, accept, push, baud_last;

    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        bit_d       = bit_q;
        baud_d      = baud_q;
        shreg_d     = shreg_q;
        txd_d       = txd_q;
        halt_seen_d = halt_seen_q;
        overflow_d  = overflow_q;
        halted_d    = halted_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        full      = (count_q == DEPTH_C);
        pop       = (state_q == IDLE) && (count_q != '0);
        accept    = instr_valid && !halt_seen_q;
        push      = accept && (!full || pop);
        baud_last = (baud_q == BAUD_MAX);

        // A halt word counts as seen even if it is dropped on overflow.
        if (accept && full && !pop) overflow_d = 1'b1;
        if (accept && instr == HALT_INSTR) halt_seen_d = 1'b1;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop) count_d = count_q + (AW + 1)'(1);
        if (pop && !push) count_d = count_q - (AW + 1)'(1);

        if (state_q == IDLE && halt_seen_q && count_q == '0) halted_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (pop) begin
                    shreg_d = mem_q[rd_ptr_q];
                    byte_d  = 2'd0;
                    baud_d  = '0;
                    state_d = START;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                    txd_d   = shreg_q[0];
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shreg_d = shreg_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = shreg_q[1];
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (byte_q == 2'd3) begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end else begin
                        byte_d  = byte_q + 2'd1;
                        state_d = START;
                        txd_d   = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            byte_q      <= '0;
            bit_q       <= '0;
            baud_q      <= '0;
            shreg_q     <= '0;
            txd_q       <= 1'b1;
            halt_seen_q <= 1'b0;
            overflow_q  <= 1'b0;
            halted_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            bit_q       <= bit_d;
            baud_q      <= baud_d;
            shreg_q     <= shreg_d;
            txd_q       <= txd_d;
            halt_seen_q <= halt_seen_d;
            overflow_q  <= overflow_d;
            halted_q    <= halted_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= instr;
    end

    assign txd       = txd_q;
    assign fifo_full = full;
    assign overflow  = overflow_q;
    assign busy      = (count_q != '0) || (state_q != IDLE);
    assign halted    = halted_q;

endmodule

// File: tb/tb_instr_trace_uart_tx.sv
// Scoreboard bench for instr_trace_uart_tx: words expected on the wire are
// queued at push time and matched against a UART decoder on txd.
module tb_instr_trace_uart_tx;

    localparam int C = 4;
    localparam int D = 4;
    localparam int WORD_CYC = 40 * C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        txd, fifo_full, overflow, busy, halted;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rx_cnt = 0;
    logic [31:0] exp_q[$];
    int starts_q[$];

    instr_trace_uart_tx #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (D),
        .HALT_INSTR  (32'h0000_0001)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_valid(instr_valid),
        .instr      (instr),
        .txd        (txd),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .busy       (busy),
        .halted     (halted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nwait(input int n, inout bit ab);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (reset) ab = 1'b1;
        end
    endtask

    // UART decoder: samples mid-bit on falling clock edges.
    initial begin : monitor
        int nbytes;
        logic [31:0] acc;
        logic [7:0] b;
        logic stopb;
        logic startb;
        bit ab;
        nbytes = 0;
        acc = '0;
        forever begin
            @(negedge clk);
            if (!reset && txd === 1'b0) begin
                ab = 1'b0;
                if (nbytes == 0) starts_q.push_back(cyc);
                nwait(2, ab);
                startb = txd;
                for (int i = 0; i < 8; i++) begin
                    nwait(C, ab);
                    b[i] = txd;
                end
                nwait(C, ab);
                stopb = txd;
                if (ab) begin
                    nbytes = 0;
                end else begin
                    chk("start_bit", {31'b0, startb}, 32'd0);
                    chk("stop_bit", {31'b0, stopb}, 32'd1);
                    acc[nbytes*8 +: 8] = b;
                    nbytes++;
                    if (nbytes == 4) begin
                        nbytes = 0;
                        rx_cnt++;
                        if (exp_q.size() == 0)
                            chk("rx_extra", exp_q.size(), 32'd1);
                        else
                            chk("rx_word", acc, exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic push1(input logic [31:0] w, input bit expect_it);
        @(negedge clk);
        instr_valid = 1'b1;
        instr = w;
        if (expect_it) exp_q.push_back(w);
        @(posedge clk);
    endtask

    task automatic stop_push();
        @(negedge clk);
        instr_valid = 1'b0;
        instr = '0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("idle_timeout", {31'b0, n < budget}, 32'd1);
        repeat (5) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int rx0;
        int lows;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_txd", {31'b0, txd}, 32'd1);
        chk("rst_full", {31'b0, fifo_full}, 32'd0);
        chk("rst_ovf", {31'b0, overflow}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // single word with exact frame timing
        push1(32'hA5C3_0F81, 1'b1);
        stop_push();
        @(posedge clk);
        #1;
        chk("single_start", {31'b0, txd}, 32'd0);
        repeat (WORD_CYC - 1) @(posedge clk);
        #1;
        chk("single_busy_end", {31'b0, busy}, 32'd1);
        @(posedge clk);
        #1;
        chk("single_done_busy", {31'b0, busy}, 32'd0);
        chk("single_done_txd", {31'b0, txd}, 32'd1);
        wait_idle(400);

        // back-to-back words, one idle cycle apart
        starts_q.delete();
        push1(32'h1234_5678, 1'b1);
        push1(32'hDEAD_BEEF, 1'b1);
        push1(32'h0000_FF00, 1'b1);
        stop_push();
        wait_idle(800);
        chk("b2b_nstarts", starts_q.size(), 32'd3);
        if (starts_q.size() == 3) begin
            chk("b2b_gap1", starts_q[1] - starts_q[0], WORD_CYC + 1);
            chk("b2b_gap2", starts_q[2] - starts_q[1], WORD_CYC + 1);
        end
        chk("b2b_ovf", {31'b0, overflow}, 32'd0);

        // push on the exact pop cycle while full
        push1(32'hAAAA_0001, 1'b1);
        push1(32'hAAAA_0002, 1'b1);
        push1(32'hAAAA_0003, 1'b1);
        push1(32'hAAAA_0004, 1'b1);
        push1(32'hAAAA_0005, 1'b1);
        #1;
        chk("pf_full", {31'b0, fifo_full}, 32'd1);
        stop_push();
        repeat (WORD_CYC - 3) @(posedge clk);
        #1;
        chk("pf_full_prepop", {31'b0, fifo_full}, 32'd1);
        push1(32'hAAAA_0006, 1'b1);
        #1;
        chk("pf_full_post", {31'b0, fifo_full}, 32'd1);
        chk("pf_ovf", {31'b0, overflow}, 32'd0);
        stop_push();
        rx0 = rx_cnt;
        wait_idle(2000);
        chk("pf_ovf_end", {31'b0, overflow}, 32'd0);

        // overflow: 7 consecutive pushes, last 2 dropped
        rx0 = rx_cnt;
        for (int i = 0; i < 7; i++) begin
            push1(32'hB000_0000 + 32'(i), i < 5);
            #1;
            if (i == 4) begin
                chk("ovf_full", {31'b0, fifo_full}, 32'd1);
                chk("ovf_before", {31'b0, overflow}, 32'd0);
            end
        end
        chk("ovf_set", {31'b0, overflow}, 32'd1);
        stop_push();
        wait_idle(2000);
        chk("ovf_nwords", rx_cnt - rx0, 32'd5);
        chk("ovf_sticky", {31'b0, overflow}, 32'd1);

        // reset during data of byte 2
        rx0 = rx_cnt;
        push1(32'hC0FF_EE42, 1'b1);
        stop_push();
        repeat (96) @(posedge clk);
        #1;
        chk("mid_txd_pre", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        exp_q.delete();
        chk("mid_txd", {31'b0, txd}, 32'd1);
        chk("mid_busy", {31'b0, busy}, 32'd0);
        chk("mid_full", {31'b0, fifo_full}, 32'd0);
        chk("mid_ovf", {31'b0, overflow}, 32'd0);
        chk("mid_halted", {31'b0, halted}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        chk("mid_idle_lows", lows, 32'd0);
        chk("mid_nwords", rx_cnt - rx0, 32'd0);

        // halt word ends the trace
        rx0 = rx_cnt;
        push1(32'h0000_0013, 1'b1);
        push1(32'h0000_0001, 1'b1);
        push1(32'h0000_0033, 1'b0);
        stop_push();
        repeat (2 * (WORD_CYC + 1) - 2) @(posedge clk);
        #1;
        chk("halt_early", {31'b0, halted}, 32'd0);
        @(posedge clk);
        #1;
        chk("halt_rise", {31'b0, halted}, 32'd1);
        chk("halt_busy", {31'b0, busy}, 32'd0);
        chk("halt_ovf", {31'b0, overflow}, 32'd0);
        chk("halt_nwords", rx_cnt - rx0, 32'd2);
        chk("halt_q_left", exp_q.size(), 32'd0);
        push1(32'h0000_0077, 1'b0);
        stop_push();
        repeat (3) @(posedge clk);
        #1;
        chk("halt_ignore_busy", {31'b0, busy}, 32'd0);
        chk("halt_sticky", {31'b0, halted}, 32'd1);
        do_reset();
        chk("halt_clr", {31'b0, halted}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
